// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: bus bit positions, the hex glyph encoding used by
// the display driver, and small helpers for the capture side.
package seg7_pkg;

  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  // Pattern order is {a,b,c,d,e,f,g}.
  localparam logic [6:0] SEG7_GLYPH [0:15] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  typedef struct packed {
    logic [3:0] nibble;
    logic       dp;
    logic       inv;
  } digit_t;

  function automatic logic is_onehot(input logic [31:0] v);
    return (v != '0) && ((v & (v - 32'd1)) == '0);
  endfunction

endpackage

// File: rtl/seg7_pattern_decoder.sv
// Combinational glyph matcher: 7-bit segment pattern to hex nibble plus an
// invalid flag for patterns (including blank) that match no glyph.
module seg7_pattern_decoder
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       invalid
);

  always_comb begin
    nibble  = '0;
    invalid = 1'b1;
    for (int unsigned g = 0; g < 16; g++) begin
      if (pattern == SEG7_GLYPH[g]) begin
        nibble  = 4'(g);
        invalid = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg7_display_capture.sv
// Samples a multiplexed 7-segment bus and rebuilds one frame per refresh cycle.
// Define SEG7_CAPTURE_ACTIVE_LOW_EN for common-anode (active-low) inputs.
module seg7_display_capture
  import seg7_pkg::*;
#(
  parameter int WIDTH_NIBBLES       = 6,
  parameter int STABLE_CYCLES       = 4,
  parameter int IDLE_TIMEOUT_CYCLES = 65536
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [7:0]                 display_led_segments,
  input  logic [WIDTH_NIBBLES-1:0]   display_led_enable_mask,
  output logic [WIDTH_NIBBLES*4-1:0] data,
  output logic [WIDTH_NIBBLES-1:0]   digit_present_mask,
  output logic [WIDTH_NIBBLES-1:0]   decimal_point_mask,
  output logic [WIDTH_NIBBLES-1:0]   digit_invalid_mask,
  output logic                       frame_valid,
  output logic                       display_idle
);

  localparam int W  = WIDTH_NIBBLES;
  localparam int SW = $clog2(STABLE_CYCLES);
  localparam int IW = $clog2(IDLE_TIMEOUT_CYCLES);

  logic [7:0]   seg_in;
  logic [W-1:0] mask_in;

`ifdef SEG7_CAPTURE_ACTIVE_LOW_EN
  assign seg_in  = ~display_led_segments;
  assign mask_in = ~display_led_enable_mask;
`else
  assign seg_in  = display_led_segments;
  assign mask_in = display_led_enable_mask;
`endif

  logic [7:0]    seg_s1, seg_s2, seg_prev;
  logic [W-1:0]  mask_s1, mask_s2, mask_prev;
  logic [SW-1:0] stab_cnt;
  logic          armed;
  logic          changed, capture, wrap, timeout;

  logic [W*4-1:0] sh_data, sh_data_nx;
  logic [W-1:0]   sh_seen, sh_seen_nx, sh_dp, sh_dp_nx, sh_inv, sh_inv_nx;
  logic [IW-1:0]  idle_cnt;

  logic [6:0] pattern;
  digit_t     cur;

  assign changed = (seg_s2 != seg_prev) || (mask_s2 != mask_prev);
  assign capture = (stab_cnt == SW'(STABLE_CYCLES - 1)) && is_onehot(32'(mask_prev)) && armed;
  assign wrap    = |(mask_prev & sh_seen);
  assign timeout = !capture && (idle_cnt == IW'(IDLE_TIMEOUT_CYCLES - 2));

  assign pattern = {seg_prev[SEG_A], seg_prev[SEG_B], seg_prev[SEG_C], seg_prev[SEG_D],
                    seg_prev[SEG_E], seg_prev[SEG_F], seg_prev[SEG_G]};
  assign cur.dp  = seg_prev[SEG_DP];

  seg7_pattern_decoder u_decoder (
    .pattern (pattern),
    .nibble  (cur.nibble),
    .invalid (cur.inv)
  );

  // Synchronizers, stability counter and arming. The capture always uses the
  // *_prev copy, which is the value the stability count refers to.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_s1    <= '0;
      seg_s2    <= '0;
      seg_prev  <= '0;
      mask_s1   <= '0;
      mask_s2   <= '0;
      mask_prev <= '0;
      stab_cnt  <= '0;
      armed     <= 1'b0;
    end else begin
      seg_s1    <= seg_in;
      seg_s2    <= seg_s1;
      seg_prev  <= seg_s2;
      mask_s1   <= mask_in;
      mask_s2   <= mask_s1;
      mask_prev <= mask_s2;
      if (changed)
        stab_cnt <= '0;
      else if (stab_cnt != SW'(STABLE_CYCLES - 1))
        stab_cnt <= stab_cnt + 1'b1;
      if (mask_s2 != mask_prev)
        armed <= 1'b1;
      else if (capture)
        armed <= 1'b0;
    end
  end

  // Next shadow contents for a capture; on a wrap the new digit starts a fresh frame.
  always_comb begin
    sh_data_nx = wrap ? '0 : sh_data;
    sh_seen_nx = wrap ? '0 : sh_seen;
    sh_dp_nx   = wrap ? '0 : sh_dp;
    sh_inv_nx  = wrap ? '0 : sh_inv;
    for (int unsigned i = 0; i < W; i++) begin
      if (mask_prev[i]) begin
        sh_data_nx[4*i +: 4] = cur.nibble;
        sh_seen_nx[i]        = 1'b1;
        sh_dp_nx[i]          = cur.dp;
        sh_inv_nx[i]         = cur.inv;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_data            <= '0;
      sh_seen            <= '0;
      sh_dp              <= '0;
      sh_inv             <= '0;
      idle_cnt           <= '0;
      data               <= '0;
      digit_present_mask <= '0;
      decimal_point_mask <= '0;
      digit_invalid_mask <= '0;
      frame_valid        <= 1'b0;
      display_idle       <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      if (capture) begin
        idle_cnt     <= '0;
        display_idle <= 1'b0;
        if (wrap) begin
          data               <= sh_data;
          digit_present_mask <= sh_seen;
          decimal_point_mask <= sh_dp;
          digit_invalid_mask <= sh_inv;
          frame_valid        <= 1'b1;
        end
        sh_data <= sh_data_nx;
        sh_seen <= sh_seen_nx;
        sh_dp   <= sh_dp_nx;
        sh_inv  <= sh_inv_nx;
      end else begin
        if (idle_cnt != IW'(IDLE_TIMEOUT_CYCLES - 1))
          idle_cnt <= idle_cnt + 1'b1;
        if (timeout) begin
          display_idle <= 1'b1;
          if (|sh_seen) begin
            data               <= sh_data;
            digit_present_mask <= sh_seen;
            decimal_point_mask <= sh_dp;
            digit_invalid_mask <= sh_inv;
            frame_valid        <= 1'b1;
            sh_data            <= '0;
            sh_seen            <= '0;
            sh_dp              <= '0;
            sh_inv             <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_display_capture.sv
// Bench for seg7_display_capture: fixed display vectors, multi-cycle corner cases
// and randomized digit sequences against a slot-level frame model.
module tb_seg7_display_capture;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  segs_drv = '0;
  logic [5:0]  mask_drv = '0;
  logic [23:0] data;
  logic [5:0]  digit_present_mask, decimal_point_mask, digit_invalid_mask;
  logic        frame_valid, display_idle;

  always #5 clk = ~clk;

  seg7_display_capture #(
    .WIDTH_NIBBLES       (6),
    .STABLE_CYCLES       (4),
    .IDLE_TIMEOUT_CYCLES (64)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .display_led_segments    (segs_drv),
    .display_led_enable_mask (mask_drv),
    .data                    (data),
    .digit_present_mask      (digit_present_mask),
    .decimal_point_mask      (decimal_point_mask),
    .digit_invalid_mask      (digit_invalid_mask),
    .frame_valid             (frame_valid),
    .display_idle            (display_idle)
  );

  typedef struct packed {
    logic [23:0] data;
    logic [5:0]  pres;
    logic [5:0]  dp;
    logic [5:0]  inv;
  } frame_t;

  typedef struct packed {
    logic [47:0] segs;
    logic [5:0]  sel;
    frame_t      exp;
  } vec_t;

  logic [6:0] gl [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  int     n_tests = 0;
  int     n_fail  = 0;
  frame_t obs_q[$];
  frame_t exp_q[$];

  always @(negedge clk)
    if (frame_valid === 1'b1)
      obs_q.push_back({data, digit_present_mask, decimal_point_mask, digit_invalid_mask});

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [7:0] s, input logic [5:0] m);
`ifdef SEG7_CAPTURE_ACTIVE_LOW_EN
    segs_drv = ~s;
    mask_drv = ~m;
`else
    segs_drv = s;
    mask_drv = m;
`endif
  endtask

  task automatic do_reset();
    drive(8'h00, 6'h00);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    obs_q.delete();
  endtask

  task automatic slot(input logic [7:0] s, input logic [5:0] m, input int gap, input int len);
    drive(8'h00, 6'h00);
    tick(gap);
    drive(s, m);
    tick(len);
  endtask

  task automatic rotation(input logic [47:0] s, input logic [5:0] sel);
    for (int i = 0; i < 6; i++)
      if (sel[i]) slot(s[8*i +: 8], 6'(1 << i), 1, 8);
  endtask

  function automatic logic [47:0] mk(input logic [23:0] nibs, input logic [5:0] dps);
    logic [47:0] r;
    for (int i = 0; i < 6; i++) r[8*i +: 8] = {gl[nibs[4*i +: 4]], dps[i]};
    return r;
  endfunction

  task automatic check_frame(input string name, input frame_t exp);
    frame_t f;
    if (obs_q.size() == 0) begin
      check({name, "_present"}, 64'd0, 64'd1);
    end else begin
      f = obs_q[obs_q.size() - 1];
      check({name, "_data"}, 64'(f.data), 64'(exp.data));
      check({name, "_pres"}, 64'(f.pres), 64'(exp.pres));
      check({name, "_dp"},   64'(f.dp),   64'(exp.dp));
      check({name, "_inv"},  64'(f.inv),  64'(exp.inv));
    end
  endtask

  initial begin
    vec_t        vecs [5];
    logic [47:0] s;
    logic [47:0] base;
    int          waited;
    int          n_before;

    base = mk(24'h1A2B3C, 6'h00);
    vecs[0] = '{base, 6'h3F, '{24'h1A2B3C, 6'h3F, 6'h00, 6'h00}};
    vecs[1] = '{base, 6'h2D, '{24'h102B0C, 6'h2D, 6'h00, 6'h00}};
    s = mk(24'h543010, 6'h01);
    s[23:16] = {7'b1001001, 1'b0};
    vecs[2] = '{s, 6'h3F, '{24'h543010, 6'h3F, 6'h01, 6'h04}};
    vecs[3] = '{mk(24'hFFFFFF, 6'h3F), 6'h3F, '{24'hFFFFFF, 6'h3F, 6'h3F, 6'h00}};
    s = mk(24'h088888, 6'h00);
    s[47:40] = 8'h00;
    vecs[4] = '{s, 6'h3F, '{24'h088888, 6'h3F, 6'h00, 6'h20}};

    do_reset();
    check("reset_data", 64'(data), 64'd0);
    check("reset_flags", 64'({digit_present_mask, decimal_point_mask, digit_invalid_mask,
                              frame_valid, display_idle}), 64'd0);

    // Table vectors: three rotations give exactly two wraps.
    for (int v = 0; v < 5; v++) begin
      do_reset();
      for (int r = 0; r < 3; r++) rotation(vecs[v].segs, vecs[v].sel);
      tick(20);
      check($sformatf("vec%0d_frames", v), 64'(obs_q.size()), 64'd2);
      check_frame($sformatf("vec%0d", v), vecs[v].exp);
    end

    // Two-cycle glitch at the start of digit 3's slot.
    do_reset();
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < 6; i++) begin
        if (i == 3) begin
          slot({gl[8], 1'b0}, 6'b001000, 1, 2);
          drive({gl[2], 1'b0}, 6'b001000);
          tick(8);
        end else begin
          slot(base[8*i +: 8], 6'(1 << i), 1, 8);
        end
      end
    tick(20);
    check("glitch_frames", 64'(obs_q.size()), 64'd2);
    check_frame("glitch", '{24'h1A2B3C, 6'h3F, 6'h00, 6'h00});

    // Activity stops after three digits: timeout publishes the partial frame.
    do_reset();
    for (int i = 0; i < 3; i++) slot(base[8*i +: 8], 6'(1 << i), 1, 8);
    drive(8'h00, 6'h00);
    check("idle_before", 64'(display_idle), 64'd0);
    waited = 0;
    while (obs_q.size() == 0 && waited < 200) begin
      tick(1);
      waited++;
    end
    check("idle_latency", 64'((waited >= 58) && (waited <= 68)), 64'd1);
    check_frame("idle", '{24'h000B3C, 6'h07, 6'h00, 6'h00});
    check("idle_set", 64'(display_idle), 64'd1);
    slot(base[31:24], 6'b001000, 1, 8);
    check("idle_cleared", 64'(display_idle), 64'd0);
    check("idle_no_extra", 64'(obs_q.size()), 64'd1);

    // Reset mid-frame discards the shadow.
    do_reset();
    rotation(base, 6'h3F);
    for (int i = 0; i < 3; i++) slot(base[8*i +: 8], 6'(1 << i), 1, 8);
    n_before = obs_q.size();
    check("mid_frames_before", 64'(n_before), 64'd1);
    drive(8'h00, 6'h00);
    reset = 1'b1;
    tick(1);
    check("mid_reset_out", 64'({data, digit_present_mask, decimal_point_mask,
                                digit_invalid_mask, frame_valid, display_idle}), 64'd0);
    reset = 1'b0;
    for (int k = 3; k < 9; k++) slot(base[8*(k%6) +: 8], 6'(1 << (k%6)), 1, 8);
    check("mid_no_early", 64'(obs_q.size()), 64'(n_before));
    slot(base[31:24], 6'b001000, 1, 8);
    tick(4);
    check("mid_fresh_count", 64'(obs_q.size()), 64'(n_before + 1));
    check_frame("mid_fresh", '{24'h1A2B3C, 6'h3F, 6'h00, 6'h00});

    // Randomized digit sequence checked against a slot-level frame model.
    begin
      logic [23:0] m_data;
      logic [5:0]  m_seen, m_dp, m_inv, last_mask;
      logic [6:0]  pat;
      logic        dpb, hit;
      logic [3:0]  nib;
      int          d, gap, len;

      do_reset();
      exp_q.delete();
      m_data = '0; m_seen = '0; m_dp = '0; m_inv = '0; last_mask = '0;
      for (int n = 0; n < 120; n++) begin
        d   = $urandom_range(0, 5);
        gap = $urandom_range(0, 2);
        len = $urandom_range(6, 12);
        pat = ($urandom_range(0, 7) == 0) ? 7'($urandom) : gl[$urandom_range(0, 15)];
        dpb = 1'($urandom);
        slot({pat, dpb}, 6'(1 << d), gap, len);
        if (gap > 0 || last_mask != 6'(1 << d)) begin
          hit = 1'b0;
          nib = '0;
          for (int g = 0; g < 16; g++)
            if (gl[g] == pat) begin
              hit = 1'b1;
              nib = 4'(g);
            end
          if (m_seen[d]) begin
            exp_q.push_back({m_data, m_seen, m_dp, m_inv});
            m_data = '0; m_seen = '0; m_dp = '0; m_inv = '0;
          end
          m_data[4*d +: 4] = nib;
          m_seen[d] = 1'b1;
          m_dp[d]   = dpb;
          m_inv[d]  = ~hit;
        end
        last_mask = 6'(1 << d);
      end
      tick(10);
      check("rand_frame_count", 64'(obs_q.size()), 64'(exp_q.size()));
      for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++)
        check($sformatf("rand_frame%0d", k), 64'(obs_q[k]), 64'(exp_q[k]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
